multicycle_ctrl_unit: RTL

//  Sequential, parametrised control unit for the RISC datapath. Accepts one opcode per

---
 rtl/ctrl_pkg.sv | 18 +
 rtl/ctrl_decode_rom.sv | 16 +
 rtl/multicycle_ctrl_unit.sv | 62 ++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared state, opcode/ALU code constants and decode-entry type for the multicycle control unit
package ctrl_pkg;
  typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;
  localparam int OPC_OP1 = 1;
  localparam int OPC_OP2 = 2;
  localparam int OPC_OP3 = 3;
  localparam int OPC_OP4 = 4;
  localparam logic [2:0] ALU_NOP = 3'd0;
  localparam logic [2:0] ALU_OP1 = 3'd1;
  localparam logic [2:0] ALU_OP2 = 3'd2;
  localparam logic [2:0] ALU_OP3 = 3'd3;
  localparam logic [2:0] ALU_OP4 = 3'd4;
  typedef struct packed {
    logic       legal;
    logic [2:0] alu_ctrl;
    logic       wr_all;
  } dec_entry_t;
endpackage

// File: rtl/ctrl_decode_rom.sv
// ctrl_decode_rom: combinational opcode to decode-entry lookup, anything outside the table is illegal
module ctrl_decode_rom
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W = 17
) (
  input  logic [OPCODE_W-1:0] opcode,
  output dec_entry_t          entry
);
  always_comb
    entry = (opcode == OPCODE_W'(OPC_OP1)) ? dec_entry_t'{legal: 1'b1, alu_ctrl: ALU_OP1, wr_all: 1'b1}
          : (opcode == OPCODE_W'(OPC_OP2)) ? dec_entry_t'{legal: 1'b1, alu_ctrl: ALU_OP2, wr_all: 1'b0}
          : (opcode == OPCODE_W'(OPC_OP3)) ? dec_entry_t'{legal: 1'b1, alu_ctrl: ALU_OP3, wr_all: 1'b0}
          : (opcode == OPCODE_W'(OPC_OP4)) ? dec_entry_t'{legal: 1'b1, alu_ctrl: ALU_OP4, wr_all: 1'b0}
          : dec_entry_t'{legal: 1'b0, alu_ctrl: ALU_NOP, wr_all: 1'b0};
endmodule

// File: rtl/multicycle_ctrl_unit.sv
// multicycle_ctrl_unit: handshake-driven IDLE/DECODE/EXEC/WB controller with ALU timeout and illegal-opcode abort
module multicycle_ctrl_unit
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W     = 17,
  parameter int ALUCTRL_W    = 3,
  parameter int NUM_REGS     = 3,
  parameter int EXEC_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  input  logic [OPCODE_W-1:0]  opcode,
  input  logic                 alu_done,
  output logic [ALUCTRL_W-1:0] alu_ctrl,
  output logic                 alu_start,
  output logic [NUM_REGS-1:0]  reg_en,
  output logic                 busy,
  output logic                 done,
  output logic                 err_illegal,
  output logic                 err_timeout
);
  localparam int CW = $clog2(EXEC_TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = CW'(EXEC_TIMEOUT - 1);
  state_t              state, state_n;
  logic [OPCODE_W-1:0] opc_q;
  logic [CW-1:0]       cnt;
  dec_entry_t          dec;
  logic                act, last;
  ctrl_decode_rom #(.OPCODE_W(OPCODE_W)) u_rom (
    .opcode(opc_q),
    .entry (dec)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      opc_q <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && instr_valid) opc_q <= opcode;
      cnt <= (state == EXEC) ? cnt + 1'b1 : '0;
    end
  end
  always_comb begin
    act         = !rst;
    last        = cnt == CNT_MAX;
    state_n     = state == IDLE   ? (instr_valid ? DECODE : IDLE)
                : state == DECODE ? (dec.legal ? EXEC : IDLE)
                : state == EXEC   ? (alu_done ? WB : last ? IDLE : EXEC)
                : IDLE;
    instr_ready = act && state == IDLE;
    busy        = act && state != IDLE;
    alu_ctrl    = busy ? ALUCTRL_W'(dec.alu_ctrl) : '0;
    alu_start   = act && state == EXEC && cnt == '0;
    reg_en      = {NUM_REGS{act && state == WB && dec.wr_all}};
    err_illegal = act && state == DECODE && !dec.legal;
    err_timeout = act && state == EXEC && last && !alu_done;
    done        = err_illegal || err_timeout || (act && state == WB);
  end
endmodule
